note_sequencer: RTL

- Autoplay and live-play scheduler for the piano tone clocks.
- Steps through an internal song table, one entry per note, timed by QUARTER_BEAT toggles.
- Routes one of the eight note clocks (C4..C5) to the speaker.
- Arbitrates between the song and live key presses: live keys always win and pause the song.

---
 rtl/piano_pkg.sv | 43 ++++
 rtl/note_sequencer_if.sv | 25 ++
 rtl/song_rom.sv | 37 +++
 rtl/note_sequencer.sv | 119 +++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared types and constants for the piano note sequencer: FSM states,
// note codes, song-entry layout and the live-key priority helper.
package piano_pkg;

  localparam int NOTE_W  = 4;
  localparam int DUR_W   = 2;
  localparam int ENTRY_W = NOTE_W + DUR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SOUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  // Lowest pressed key wins; returns its note code, or rest if none pressed.
  function automatic logic [NOTE_W-1:0] lowest_key_note(input logic [7:0] keys);
    lowest_key_note = NOTE_REST;
    for (int i = 7; i >= 0; i--) begin
      if (keys[i]) lowest_key_note = NOTE_W'(i + 1);
    end
  endfunction

  function automatic logic is_pitch(input logic [NOTE_W-1:0] note);
    return (note >= NOTE_C4) && (note <= NOTE_C5);
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Signal bundle between the note sequencer and its environment
// (tone clocks, beat, keys and transport controls in; speaker and status out).
interface note_sequencer_if #(parameter int ADDR_W = 4);
  logic [7:0]        NOTE_CLKS;
  logic              QUARTER_BEAT;
  logic [7:0]        KEYS;
  logic              START;
  logic              STOP;
  logic              SPEAKER;
  logic [3:0]        CUR_NOTE;
  logic [ADDR_W-1:0] SONG_IDX;
  logic              BUSY;
  logic              LIVE;
  logic              SONG_DONE;

  modport master (
    output NOTE_CLKS, QUARTER_BEAT, KEYS, START, STOP,
    input  SPEAKER, CUR_NOTE, SONG_IDX, BUSY, LIVE, SONG_DONE
  );

  modport slave (
    input  NOTE_CLKS, QUARTER_BEAT, KEYS, START, STOP,
    output SPEAKER, CUR_NOTE, SONG_IDX, BUSY, LIVE, SONG_DONE
  );
endinterface

// File: rtl/song_rom.sv
// Built-in song table: one {note, dur} entry per index, dur+1 beats each.
// Indices at or beyond SONG_LEN read back as a one-beat rest.
module song_rom
  import piano_pkg::*;
#(
  parameter int SONG_LEN = 16,
  parameter int ADDR_W   = 4
) (
  input  logic [ADDR_W-1:0] addr,
  output entry_t            entry
);

  // NOTE: a constant table is pure decode logic, so there is nothing to reset.
  always_comb begin
    entry = '{note: NOTE_REST, dur: 2'd0};
    if (int'(addr) < SONG_LEN) begin
      case (int'(addr))
        0:  entry = '{note: NOTE_C4,   dur: 2'd1};
        1:  entry = '{note: NOTE_G4,   dur: 2'd0};
        2:  entry = '{note: NOTE_A4,   dur: 2'd3};
        3:  entry = '{note: NOTE_C5,   dur: 2'd0};
        4:  entry = '{note: NOTE_REST, dur: 2'd1};
        5:  entry = '{note: NOTE_E4,   dur: 2'd1};
        6:  entry = '{note: NOTE_D4,   dur: 2'd0};
        7:  entry = '{note: NOTE_F4,   dur: 2'd2};
        8:  entry = '{note: NOTE_B4,   dur: 2'd0};
        9:  entry = '{note: 4'd9,      dur: 2'd1};
        10: entry = '{note: NOTE_G4,   dur: 2'd1};
        11: entry = '{note: NOTE_E4,   dur: 2'd0};
        12: entry = '{note: NOTE_D4,   dur: 2'd1};
        13: entry = '{note: NOTE_C4,   dur: 2'd3};
        default: entry = '{note: NOTE_REST, dur: 2'd0};
      endcase
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Song/live-play scheduler: walks the song table on beat ticks, lets live
// keys pre-empt (and freeze) the song, and routes the chosen tone to SPEAKER.
module note_sequencer
  import piano_pkg::*;
#(
  parameter int SONG_LEN = 16,
  parameter int ADDR_W   = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  note_sequencer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [NOTE_W-1:0] song_note, song_note_nxt;
  logic [NOTE_W-1:0] live_note, cur_note;
  logic [2:0]        beats_left, beats_nxt;
  logic              qb_d, start_d, live_r, speaker_r;
  logic              beat_tick, start_rise;
  entry_t            rom_entry;

  song_rom #(.SONG_LEN(SONG_LEN), .ADDR_W(ADDR_W)) u_rom (
    .addr  (idx),
    .entry (rom_entry)
  );

  assign beat_tick  = bus.QUARTER_BEAT ^ qb_d;
  assign start_rise = bus.START & ~start_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      idx        <= '0;
      song_note  <= NOTE_REST;
      beats_left <= '0;
      qb_d       <= 1'b0;
      start_d    <= 1'b0;
      live_r     <= 1'b0;
      live_note  <= NOTE_REST;
      speaker_r  <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      song_note  <= song_note_nxt;
      beats_left <= beats_nxt;
      qb_d       <= bus.QUARTER_BEAT;
      start_d    <= bus.START;
      live_r     <= |bus.KEYS;
      live_note  <= lowest_key_note(bus.KEYS);
      speaker_r  <= is_pitch(cur_note) ? bus.NOTE_CLKS[3'(cur_note - 4'd1)] : 1'b0;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    song_note_nxt = song_note;
    beats_nxt     = beats_left;
    case (state)
      IDLE: begin
        if (start_rise && !bus.STOP) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
        end
      end
      LOAD: begin
        song_note_nxt = rom_entry.note;
        beats_nxt     = 3'(rom_entry.dur) + 3'd1;
        state_nxt     = SOUND;
      end
      SOUND: begin
        // Held keys freeze the song: ticks are simply not counted.
        if (beat_tick && !live_r) begin
          if (beats_left == 3'd1) begin
            beats_nxt = '0;
            if (idx == LAST_IDX) begin
              state_nxt = DONE;
            end else begin
              state_nxt = LOAD;
              idx_nxt   = idx + ADDR_W'(1);
            end
          end else begin
            beats_nxt = beats_left - 3'd1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides whatever the song would have done this cycle.
    if (bus.STOP && state != IDLE) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      beats_nxt = '0;
    end
  end

  always_comb begin
    cur_note = NOTE_REST;
    if (live_r)              cur_note = live_note;
    else if (state == SOUND) cur_note = song_note;
  end

  assign bus.CUR_NOTE  = cur_note;
  assign bus.SPEAKER   = speaker_r;
  assign bus.SONG_IDX  = idx;
  assign bus.BUSY      = (state != IDLE);
  assign bus.LIVE      = live_r;
  assign bus.SONG_DONE = (state == DONE) && !bus.STOP;

endmodule
